spi_sfr_slave: RTL and testbench
================================

SPI_SFR_SLAVE -- requirements
Module: spi_sfr_slave

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth for spi_sck/spi_csn/spi_mosi (allowed values 2..4).
REQ-002 clk  in  1  single system clock; all logic is synchronous to it.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 spi_csn  in  1  chip select, active-low, asynchronous.
REQ-006 spi_mosi  in  1  serial data in, MSB first.
REQ-007 spi_miso  out  1  serial data out, MSB first.
REQ-008 wr_addr  out  12  SFR write address.
REQ-009 wr_data  out  16  SFR write data.
REQ-010 wr_en  out  1  one-clk SFR write strobe.
REQ-011 rd_addr  out  12  SFR read address.
REQ-012 rd_en  out  1  one-clk SFR read strobe.
REQ-013 tx_data  in  16  SFR read data, valid 1 clk after rd_en.
REQ-014 busy  out  1  high while a frame is in progress (spi_csn low, synchronized).

Function
REQ-015 Frame = 32 bits: bit31 R/W (1=read), bits30:28 ignored, bits27:16 address, bits15:0 data.
REQ-016 spi_sck, spi_csn and spi_mosi SHALL pass through SYNC_STAGES flops; SCK rising/falling edges are detected on the synchronized signal.
REQ-017 Required ratio: f_clk >= 8 x f_sck; behaviour below this ratio is undefined.
REQ-018 MOSI is sampled on each detected SCK rising edge; MISO changes only on detected SCK falling edges.
REQ-019 FSM states: IDLE, HDR, DATA, DONE.
REQ-020 IDLE -> HDR on synchronized spi_csn falling edge; bit counter cleared to 0.
REQ-021 HDR: shifts in 16 bits; on the 16th rising edge latch addr and R/W, then go to DATA.
REQ-022 On the HDR->DATA transition with R/W=1: rd_addr <= addr and rd_en pulses for exactly 1 clk.
REQ-023 The clk after rd_en, tx_data is captured into the MISO shift register; bit15 is driven at the 16th SCK falling edge, and bits 14..0 follow on successive falling edges.
REQ-024 MISO is 0 during HDR, during write frames, and in IDLE/DONE.
REQ-025 DATA: shifts in 16 bits; on the 32nd rising edge of a write frame, wr_addr/wr_data are updated and wr_en pulses for exactly 1 clk, then go to DONE.
REQ-026 On the 32nd rising edge of a read frame, go to DONE with no strobe.
REQ-027 DONE: additional SCK edges are ignored (no strobes, MISO=0) until spi_csn rises.
REQ-028 A synchronized spi_csn rise in any state -> IDLE next clk.
REQ-029 A frame aborted before the 32nd edge SHALL produce no wr_en; rd_en may already have fired if the abort came after bit 16.
REQ-030 Back-to-back frames separated by spi_csn high for at least 2 SCK periods SHALL each be decoded independently.
REQ-031 wr_addr, wr_data and rd_addr hold their last value between strobes.

Reset
REQ-032 When rst_n is low: FSM=IDLE, counter=0, shift registers=0, wr_addr/wr_data/rd_addr=0, wr_en/rd_en/busy/spi_miso=0, synchronizers preset to spi_csn=1, spi_sck=0.
REQ-033 Reset mid-frame discards the frame with no strobes; after rst_n rises, decoding restarts only on the next spi_csn falling edge.

Configuration
REQ-034 Macro SPI_SFR_SLAVE_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit), which pulses for 1 clk when spi_csn rises with a bit count in 1..31, and adds output err_cnt (8 bits, saturating at 255, reset 0).
- Undefined: these ports are absent and aborted frames are dropped silently.

Verification
REQ-035 Write frame 0x0001_000A -> wr_addr=0x001, wr_data=0x000A, wr_en high for exactly 1 clk, rd_en never asserts.
REQ-036 Read frame header 0x8123, with tx_data=0xBEEF presented 1 clk after rd_en -> rd_addr=0x123, rd_en 1 clk, MISO bits15..0 = 0xBEEF, wr_en never asserts.
REQ-037 Write frame 0x0005_1234 with spi_csn raised after 20 bits -> no wr_en; with macro defined, frame_err pulses once and err_cnt=1.
REQ-038 40-bit write frame 0x0002_5555 followed by 8 extra bits -> exactly one wr_en with wr_data=0x5555; the extra bits are ignored.
REQ-039 rst_n pulsed low after bit 24 of a write frame, then a fresh read frame to 0x010 -> no wr_en; rd_en fires with rd_addr=0x010.
REQ-040 Two back-to-back write frames 0x0003_0001 and 0x0004_0002 at f_clk = 8 x f_sck -> two wr_en pulses with the correct address/data pairs.

Source files
------------

// File: rtl/spi_sfr_slave.sv
// SPI mode-0 slave that decodes 32-bit frames into SFR read/write strobes.
// Optional SPI_SFR_SLAVE_FRAME_ERR_EN adds frame_err / err_cnt outputs for aborted frames.
module spi_sfr_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [11:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic [11:0] rd_addr,
    output logic        rd_en,
    input  logic [15:0] tx_data,
    output logic        busy
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
    ,
    output logic        frame_err,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q, fill_q;
    logic                   sck_prev_q, csn_prev_q, armed_q;
    logic [5:0]             cnt_q;
    logic [15:0]            rx_q, tx_q;
    logic                   rw_q, rd_pend_q;
    logic [11:0]            addr_q;

    logic        sck_s, csn_s, mosi_s;
    logic        sck_rise, sck_fall, csn_fall, csn_rise;
    logic [15:0] rx_d, tx_d;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // A CS low that was already present when reset released is not a new frame.
    assign csn_fall = armed_q & csn_prev_q & ~csn_s;
    assign csn_rise = csn_s & ~csn_prev_q;
    assign rx_d     = {rx_q[14:0], mosi_s};
    // Read data arriving in the same cycle as a falling edge is used directly.
    assign tx_d     = rd_pend_q ? tx_data : tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            addr_q      <= '0;
            spi_miso    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= 1'b0;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
            frame_err   <= 1'b0;
            err_cnt     <= '0;
`endif
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & csn_s);
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
            busy        <= ~csn_s;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            rd_pend_q   <= rd_en;
            if (rd_pend_q) tx_q <= tx_data;
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
            frame_err   <= 1'b0;
`endif
            if (csn_rise) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                spi_miso <= 1'b0;
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
                if (cnt_q != 6'd0 && !cnt_q[5]) begin
                    frame_err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        if (csn_fall) begin
                            state_q <= HDR;
                            cnt_q   <= '0;
                            rx_q    <= '0;
                        end
                    end
                    HDR: begin
                        spi_miso <= 1'b0;
                        if (sck_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_q + 6'd1;
                            if (cnt_q == 6'd15) begin
                                rw_q    <= rx_d[15];
                                addr_q  <= rx_d[11:0];
                                state_q <= DATA;
                                if (rx_d[15]) begin
                                    rd_addr <= rx_d[11:0];
                                    rd_en   <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sck_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_q + 6'd1;
                            if (cnt_q == 6'd31) begin
                                state_q  <= DONE;
                                spi_miso <= 1'b0;
                                if (!rw_q) begin
                                    wr_addr <= addr_q;
                                    wr_data <= rx_d;
                                    wr_en   <= 1'b1;
                                end
                            end
                        end else if (sck_fall) begin
                            if (rw_q) begin
                                spi_miso <= tx_d[15];
                                tx_q     <= {tx_d[14:0], 1'b0};
                            end else begin
                                spi_miso <= 1'b0;
                            end
                        end
                    end
                    default: spi_miso <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sfr_slave.sv
// Self-checking bench for spi_sfr_slave: directed frame table, reset sequence, random frames.
`timescale 1ns/1ps
module tb_spi_sfr_slave;

    typedef struct {
        logic [63:0] v;
        int          n;
        bit          wr;
        logic [11:0] wa;
        logic [15:0] wd;
        bit          rd;
        logic [11:0] ra;
        bit          chk_miso;
        logic [15:0] miso;
    } vec_t;

    logic        clk, rst_n, spi_sck, spi_csn, spi_mosi, spi_miso;
    logic [11:0] wr_addr, rd_addr;
    logic [15:0] wr_data, tx_data;
    logic        wr_en, rd_en, busy;
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
    logic        frame_err;
    logic [7:0]  err_cnt;
    int          err_pulses;
    int          err_exp;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [4096];
    logic [27:0] wr_log [$];
    logic [11:0] rd_log [$];

    spi_sfr_slave #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_csn  (spi_csn),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .tx_data  (tx_data),
        .busy     (busy)
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err),
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SFR side: read data appears the clock after rd_en.
    always @(posedge clk) if (rd_en) tx_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (rd_en) rd_log.push_back(rd_addr);
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        if (frame_err) err_pulses++;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        #40 spi_sck = 1'b1;
        m = spi_miso;
        #40 spi_sck = 1'b0;
    endtask

    // Master side of one frame: MISO word sampled on rises 16..31, OR of MISO during header.
    task automatic spi_xfer(input logic [63:0] v, input int n,
                            output logic [15:0] mw, output logic hdr_any, output logic busy_mid);
        logic m;
        mw = '0;
        hdr_any = 1'b0;
        busy_mid = 1'b0;
        spi_csn = 1'b0;
        #40;
        for (int k = 0; k < n; k++) begin
            send_bit(v[n-1-k], m);
            if (k < 16) hdr_any = hdr_any | m;
            else if (k < 32) mw = {mw[14:0], m};
            if (k == n-1) busy_mid = busy;
        end
        #40 spi_csn = 1'b1;
        #160;
    endtask

    // Reference: decode the frame from the bit rules alone.
    function automatic vec_t model(input logic [63:0] v, input int n);
        vec_t t;
        logic [15:0] hdr;
        logic [63:0] sh;
        t = '{v: v, n: n, wr: 0, wa: 0, wd: 0, rd: 0, ra: 0, chk_miso: 0, miso: 0};
        if (n >= 16) begin
            sh  = v >> (n - 16);
            hdr = sh[15:0];
            if (hdr[15]) begin
                t.rd = 1;
                t.ra = hdr[11:0];
                if (n >= 32) begin
                    t.chk_miso = 1;
                    t.miso = mem[hdr[11:0]];
                end
            end else if (n >= 32) begin
                sh = v >> (n - 32);
                t.wr = 1;
                t.wa = hdr[11:0];
                t.wd = sh[15:0];
                t.chk_miso = 1;
            end
        end
        return t;
    endfunction

    task automatic run_vec(input vec_t t, input string tag);
        logic [15:0] mw;
        logic hdr_any, busy_mid;
        wr_log.delete();
        rd_log.delete();
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        err_pulses = 0;
        if (t.n >= 1 && t.n <= 31 && err_exp < 255) err_exp++;
`endif
        spi_xfer(t.v, t.n, mw, hdr_any, busy_mid);
        $display("frame %s n=%0d v=0x%0h wr=%0d rd=%0d miso=0x%04h", tag, t.n, t.v,
                 wr_log.size(), rd_log.size(), mw);
        check({tag, " wr_cnt"}, 32'(wr_log.size()), 32'(t.wr));
        if (t.wr && wr_log.size() > 0) begin
            check({tag, " wr_addr"}, 32'(wr_log[0][27:16]), 32'(t.wa));
            check({tag, " wr_data"}, 32'(wr_log[0][15:0]), 32'(t.wd));
        end
        check({tag, " rd_cnt"}, 32'(rd_log.size()), 32'(t.rd));
        if (t.rd && rd_log.size() > 0) check({tag, " rd_addr"}, 32'(rd_log[0]), 32'(t.ra));
        check({tag, " miso_hdr"}, 32'(hdr_any), 32'd0);
        if (t.chk_miso) check({tag, " miso_data"}, 32'(mw), 32'(t.miso));
        check({tag, " busy_mid"}, 32'(busy_mid), 32'd1);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        check({tag, " frame_err"}, 32'(err_pulses), (t.n >= 1 && t.n <= 31) ? 32'd1 : 32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(err_exp));
`endif
    endtask

    vec_t tbl [9];

    initial begin
        logic m;
        logic [63:0] rv;
        int rn, sel;
        vec_t t;

        rst_n = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0; tx_data = '0;
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        err_exp = 0;
        err_pulses = 0;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h123] = 16'hBEEF;

        tbl[0] = '{64'h0001_000A,     32, 1, 12'h001, 16'h000A, 0, 12'h000, 1, 16'h0000};
        tbl[1] = '{64'h8123_0000,     32, 0, 12'h000, 16'h0000, 1, 12'h123, 1, 16'hBEEF};
        tbl[2] = '{64'h0_0051,        20, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 16'h0000};
        tbl[3] = '{64'h00_0002_5555_A5, 40, 1, 12'h002, 16'h5555, 0, 12'h000, 1, 16'h0000};
        tbl[4] = '{64'h0003_0001,     32, 1, 12'h003, 16'h0001, 0, 12'h000, 1, 16'h0000};
        tbl[5] = '{64'h0004_0002,     32, 1, 12'h004, 16'h0002, 0, 12'h000, 1, 16'h0000};
        tbl[6] = '{64'h8_4560,        20, 0, 12'h000, 16'h0000, 1, 12'h456, 0, 16'h0000};
        tbl[7] = '{64'h7ABC_1357,     32, 1, 12'hABC, 16'h1357, 0, 12'h000, 1, 16'h0000};
        tbl[8] = '{64'hFF,             8, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 16'h0000};

        #53;
        check("rst wr_en",    32'(wr_en),    32'd0);
        check("rst rd_en",    32'(rd_en),    32'd0);
        check("rst wr_addr",  32'(wr_addr),  32'd0);
        check("rst wr_data",  32'(wr_data),  32'd0);
        check("rst rd_addr",  32'(rd_addr),  32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst miso",     32'(spi_miso), 32'd0);
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        check("rst err_cnt",  32'(err_cnt),  32'd0);
`endif
        rst_n = 1'b1;
        #100;

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset mid-frame after bit 24; CS stays low across reset.
        wr_log.delete();
        rd_log.delete();
        rv = 64'h0006_7777;
        spi_csn = 1'b0;
        #40;
        for (int k = 0; k < 24; k++) send_bit(rv[31-k], m);
        rst_n = 1'b0;
        #30;
        check("midrst wr_addr", 32'(wr_addr), 32'd0);
        check("midrst wr_data", 32'(wr_data), 32'd0);
        check("midrst rd_addr", 32'(rd_addr), 32'd0);
        check("midrst busy",    32'(busy),    32'd0);
`ifdef SPI_SFR_SLAVE_FRAME_ERR_EN
        err_exp = 0;
`endif
        rst_n = 1'b1;
        for (int k = 24; k < 32; k++) send_bit(rv[31-k], m);
        #40 spi_csn = 1'b1;
        #160;
        $display("frame midrst n=32 v=0x%0h wr=%0d rd=%0d", rv, wr_log.size(), rd_log.size());
        check("midrst wr_cnt", 32'(wr_log.size()), 32'd0);
        check("midrst rd_cnt", 32'(rd_log.size()), 32'd0);
        run_vec(model(64'h8010_0000, 32), "postrst");

        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) rn = 32;
            else if (sel < 8) rn = int'($urandom_range(1, 31));
            else rn = int'($urandom_range(33, 40));
            rv = {32'($urandom), 32'($urandom)};
            rv = rv & ((64'd1 << rn) - 64'd1);
            t = model(rv, rn);
            run_vec(t, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
